// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the program-load harness.
//   - DEF_INST_W / DEF_DATA_W : default instruction and data widths
//   - state_e                 : harness sequencing states
// -----------------------------------------------------------------------------
package proc_pkg;

  localparam int DEF_INST_W = 32;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/prog_mem.sv
// -----------------------------------------------------------------------------
// prog_mem
// DEPTH x INST_W instruction store: synchronous write, asynchronous read.
// Contents are not cleared by reset.
// Ports:
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational)
// -----------------------------------------------------------------------------
module prog_mem
  import proc_pkg::*;
#(
  parameter int INST_W = DEF_INST_W,
  parameter int DEPTH  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [INST_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [INST_W-1:0]        o_rdata
);

  logic [INST_W-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Program-load and self-check harness for the processor core. Streams a
// program into a private instruction memory while holding the core in reset,
// then runs it, serves fetches, and reports pass/fail/timeout on halt.
//
// Optional feature: define PROG_LOADER_CHECKSUM_EN to build a running sum of
// accepted load words on csum; otherwise csum is tied to zero.
//
// Ports:
//   clk, sys_rst           : clock, synchronous active-high reset
//   ld_valid/ld_ready      : load handshake; ld_data word, ld_last end marker
//   start                  : run / re-run request
//   exp_dout               : expected final processor dout
//   imem_raddr/imem_rdata  : processor fetch port (asynchronous read)
//   proc_rst               : reset to processor core
//   proc_halt, proc_dout   : processor halt indication and data output
//   word_cnt, cyc_cnt      : words loaded, RUN cycles elapsed
//   done, pass, timeout    : result flags
//   csum                   : load checksum
// -----------------------------------------------------------------------------
module prog_loader
  import proc_pkg::*;
#(
  parameter int INST_W  = DEF_INST_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         sys_rst,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [INST_W-1:0]            ld_data,
  input  logic                         ld_last,
  input  logic                         start,
  input  logic [DATA_W-1:0]            exp_dout,
  input  logic [$clog2(DEPTH)-1:0]     imem_raddr,
  output logic [INST_W-1:0]            imem_rdata,
  output logic                         proc_rst,
  input  logic                         proc_halt,
  input  logic [DATA_W-1:0]            proc_dout,
  output logic [$clog2(DEPTH):0]       word_cnt,
  output logic [$clog2(TIMEOUT+1)-1:0] cyc_cnt,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [INST_W-1:0]            csum
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]      L_WCNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      L_WCNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0] L_CYC_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_CYC_LAST  = CNT_W'(TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_accept;
  logic              w_run_go;
  logic              w_halt_hit;
  logic              w_to_hit;

  logic [AW:0]       r_word_cnt;
  logic [CNT_W-1:0]  r_cyc_cnt;
  logic              r_proc_rst;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [INST_W-1:0] w_mem_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_run_go    = 1'b0;
    w_halt_hit  = 1'b0;
    w_to_hit    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_accept = ld_valid;
        // The word written at index DEPTH-1 fills memory, so it closes the load
        if (ld_valid && (ld_last || (r_word_cnt == L_WCNT_LAST))) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_ARMED, ST_DONE: begin
        if (start) begin
          w_run_go    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RUN: begin
        // Halt takes priority over a timeout landing in the same cycle
        if (proc_halt) begin
          w_halt_hit  = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_cyc_cnt == L_CYC_LAST) begin
          w_to_hit    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // Load counter, run counter, core reset and result flags
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_word_cnt <= {(AW+1){1'b0}};
      r_cyc_cnt  <= {CNT_W{1'b0}};
      r_proc_rst <= 1'b1;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word_cnt <= r_word_cnt + L_WCNT_ONE;
      end
      if (w_run_go) begin
        r_cyc_cnt  <= {CNT_W{1'b0}};
        r_proc_rst <= 1'b0;
        r_done     <= 1'b0;
        r_pass     <= 1'b0;
        r_timeout  <= 1'b0;
      end else if (r_state == ST_RUN) begin
        // Counts every RUN cycle, including the one that ends the run
        r_cyc_cnt <= r_cyc_cnt + L_CYC_ONE;
        if (w_halt_hit) begin
          r_proc_rst <= 1'b1;
          r_done     <= 1'b1;
          r_pass     <= (proc_dout == exp_dout);
          r_timeout  <= 1'b0;
        end else if (w_to_hit) begin
          r_proc_rst <= 1'b1;
          r_done     <= 1'b1;
          r_pass     <= 1'b0;
          r_timeout  <= 1'b1;
        end
      end
    end
  end

  prog_mem #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_prog_mem (
    .i_clk   (clk),
    .i_we    (w_accept),
    .i_waddr (r_word_cnt[AW-1:0]),
    .i_wdata (ld_data),
    .i_raddr (imem_raddr),
    .o_rdata (w_mem_rdata)
  );

  // Locations beyond the loaded program read as zero, hiding stale contents
  assign imem_rdata = ({1'b0, imem_raddr} < r_word_cnt) ? w_mem_rdata : {INST_W{1'b0}};

  assign ld_ready = (r_state == ST_LOAD);
  assign word_cnt = r_word_cnt;
  assign cyc_cnt  = r_cyc_cnt;
  assign proc_rst = r_proc_rst;
  assign done     = r_done;
  assign pass     = r_pass;
  assign timeout  = r_timeout;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [INST_W-1:0] r_csum;

  // Running modulo-2^INST_W sum of accepted load words
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_csum <= {INST_W{1'b0}};
    end else if (w_accept) begin
      r_csum <= r_csum + ld_data;
    end
  end

  assign csum = r_csum;
`else
  assign csum = {INST_W{1'b0}};
`endif

endmodule
